// File: rtl/feature_pingpong_ctrl_if.sv
// Fill/consume handshake between the feature ping-pong scheduler and its
// producer (feature fetcher) and consumer (line-buffer reader).
interface feature_pingpong_ctrl_if #(
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 fill_req;
  logic [TAG_WIDTH-1:0] fill_tag;
  logic                 fill_grant;
  logic                 fill_sel;
  logic                 fill_busy;
  logic                 fill_done;
  logic                 comp_req;
  logic                 comp_grant;
  logic                 comp_sel;
  logic [TAG_WIDTH-1:0] comp_tag;
  logic                 comp_busy;
  logic                 comp_done;

  // master: fetcher/reader side
  modport master (
    output fill_req, fill_tag, fill_done, comp_req, comp_done,
    input  fill_grant, fill_sel, fill_busy, comp_grant, comp_sel, comp_tag, comp_busy
  );

  // slave: scheduler side
  modport slave (
    input  fill_req, fill_tag, fill_done, comp_req, comp_done,
    output fill_grant, fill_sel, fill_busy, comp_grant, comp_sel, comp_tag, comp_busy
  );
endinterface

// File: rtl/feature_pingpong_ctrl.sv
// Ping-pong scheduler for the two input feature banks: grants banks to the
// fetcher and line-buffer reader in strict alternation and carries fill tags.
module feature_pingpong_ctrl #(
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  feature_pingpong_ctrl_if.slave    bus,
  input  logic                      flush,
  output logic [1:0]                bank_full,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic                      err
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_BUSY    = 2'd3
  } bank_state_t;

  bank_state_t          bank_q [2];
  logic [TAG_WIDTH-1:0] tag_q  [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 fill_busy_q;
  logic                 comp_busy_q;
  logic                 fill_grant_q;
  logic                 comp_grant_q;
  logic [TAG_WIDTH-1:0] comp_tag_q;
  logic [CNT_WIDTH-1:0] stall_q;
  logic                 err_q;

  logic fill_ok;
  logic comp_ok;
  logic stall_hit;

  always_comb begin
    fill_ok   = bus.fill_req && !fill_busy_q && (bank_q[wr_ptr] == BANK_EMPTY) && !flush;
    comp_ok   = bus.comp_req && !comp_busy_q && (bank_q[rd_ptr] == BANK_FULL) && !flush;
    stall_hit = bus.comp_req && !comp_busy_q && (bank_q[rd_ptr] != BANK_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      tag_q[0]     <= '0;
      tag_q[1]     <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fill_busy_q  <= 1'b0;
      comp_busy_q  <= 1'b0;
      fill_grant_q <= 1'b0;
      comp_grant_q <= 1'b0;
      comp_tag_q   <= '0;
      stall_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      fill_grant_q <= 1'b0;
      comp_grant_q <= 1'b0;
      if (flush) begin
        // abort in-flight work; tags, stall count and error history survive
        bank_q[0]   <= BANK_EMPTY;
        bank_q[1]   <= BANK_EMPTY;
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
        fill_busy_q <= 1'b0;
        comp_busy_q <= 1'b0;
      end else begin
        if (fill_ok) begin
          bank_q[wr_ptr] <= BANK_FILLING;
          tag_q[wr_ptr]  <= bus.fill_tag;
          fill_busy_q    <= 1'b1;
          fill_grant_q   <= 1'b1;
        end
        if (bus.fill_done) begin
          if (fill_busy_q) begin
            bank_q[wr_ptr] <= BANK_FULL;
            fill_busy_q    <= 1'b0;
            wr_ptr         <= ~wr_ptr;
          end else begin
            err_q <= 1'b1;
          end
        end
        if (comp_ok) begin
          bank_q[rd_ptr] <= BANK_BUSY;
          comp_tag_q     <= tag_q[rd_ptr];
          comp_busy_q    <= 1'b1;
          comp_grant_q   <= 1'b1;
        end
        if (bus.comp_done) begin
          if (comp_busy_q) begin
            bank_q[rd_ptr] <= BANK_EMPTY;
            comp_busy_q    <= 1'b0;
            rd_ptr         <= ~rd_ptr;
          end else begin
            err_q <= 1'b1;
          end
        end
        if (stall_hit && (stall_q != '1)) begin
          stall_q <= stall_q + 1'b1;
        end
      end
    end
  end

  assign bus.fill_grant = fill_grant_q;
  assign bus.fill_sel   = wr_ptr;
  assign bus.fill_busy  = fill_busy_q;
  assign bus.comp_grant = comp_grant_q;
  assign bus.comp_sel   = rd_ptr;
  assign bus.comp_tag   = comp_tag_q;
  assign bus.comp_busy  = comp_busy_q;
  assign bank_full      = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};
  assign stall_cnt      = stall_q;
  assign err            = err_q;

endmodule

// File: doc/feature_pingpong_ctrl.md
# feature_pingpong_ctrl

Scheduler for the two input feature banks (feature_in_memory_0/1). It hands banks to the feature fetcher (producer) and the line-buffer reader (consumer) in strict ping-pong order, tracks each bank's fill/consume state and carries a per-fill tag to the consumer. Its outputs drive the feature write-bank select and feature_in_select, replacing the static select fields taken from the instruction.

## Interface
- TAG_WIDTH, 8, width of tag attached to each fill (tile/row index from the instruction)
- CNT_WIDTH, 16, width of consumer stall counter
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- fill_req  in  1  level; fetcher wants a bank to fill
- fill_tag  in  TAG_WIDTH  tag sampled with the fill grant
- fill_grant  out  1  one-cycle pulse; fill may start
- fill_sel  out  1  bank to write (wr_ptr)
- fill_busy  out  1  a fill is in flight
- fill_done  in  1  pulse; active fill complete
- comp_req  in  1  level; reader wants a full bank
- comp_grant  out  1  one-cycle pulse; reading may start
- comp_sel  out  1  bank to read (rd_ptr)
- comp_tag  out  TAG_WIDTH  tag of granted bank, held until next comp_grant
- comp_busy  out  1  a read is in flight
- comp_done  in  1  pulse; active read complete
- flush  in  1  pulse; abort everything, all banks EMPTY
- bank_full  out  2  bit i = bank i FULL
- stall_cnt  out  CNT_WIDTH  saturating consumer stall cycles
- err  out  1  sticky protocol error

## Operation
- Per-bank state, 2 bits: EMPTY -> FILLING (fill grant) -> FULL (fill_done) -> BUSY (comp grant) -> EMPTY (comp_done).
- wr_ptr/rd_ptr 1 bit each; wr_ptr toggles on accepted fill_done, rd_ptr on accepted comp_done. fill_sel = wr_ptr, comp_sel = rd_ptr; both stable for a whole fill/read.
- Fill grant when fill_req && !fill_busy && bank[wr_ptr]==EMPTY && !flush. Grant sets bank[wr_ptr]=FILLING, fill_busy=1, tag[wr_ptr]=fill_tag.
- Comp grant when comp_req && !comp_busy && bank[rd_ptr]==FULL && !flush. Grant sets bank[rd_ptr]=BUSY, comp_busy=1, comp_tag=tag[rd_ptr].
- Only one fill and one read in flight; a request still high after its grant is not re-granted until the matching done, so level requests are safe.
- fill_done with fill_busy: bank[wr_ptr]=FULL, fill_busy=0, toggle wr_ptr. comp_done with comp_busy: bank[rd_ptr]=EMPTY, comp_busy=0, toggle rd_ptr.
- fill_done without fill_busy, or comp_done without comp_busy: ignored, err=1 (sticky, reset-only clear).
- Fill and read on different banks run concurrently; same-cycle fill_done and comp_done are both applied.
- stall_cnt increments each cycle comp_req && !comp_busy && bank[rd_ptr]!=FULL; saturates at all ones; reset-only clear.
- flush has priority over everything in its cycle: banks EMPTY, ptrs 0, busy flags 0, no grants, dones in that cycle ignored (no err). Tags, comp_tag, stall_cnt, err kept. A done arriving after flush for an aborted op sets err.

## Timing
- All outputs registered. Reset values: every output 0, both banks EMPTY, ptrs 0, tags 0.
- req at edge t with conditions true -> grant high in cycle t+1, state/busy updated same edge.
- fill_done at t -> bank FULL at t+1 -> earliest comp_grant t+2.
- comp_done at t -> bank EMPTY at t+1 -> earliest fill_grant t+2.
- fill_done at t -> fill_busy low at t+1 -> next fill_grant at t+2 if the other bank is EMPTY.
- rst mid-operation: all state returns to reset values next edge; outstanding dones after reset set err.

## Test plan
- Ping-pong: 4 fills (tags 0x11,0x22,0x33,0x44) interleaved with 4 reads -> fill_sel 0,1,0,1; comp_sel 0,1,0,1; comp_tag 0x11..0x44 in order; err=0.
- Back-pressure: 2 fills, no comp_req, fill_req held -> bank_full=2'b11, no third fill_grant until comp_done; then fill_grant exactly 2 cycles after comp_done.
- Starvation: comp_req held 10 cycles with both banks EMPTY -> stall_cnt=10, no comp_grant; after fill_done comp_grant 2 cycles later.
- Concurrency: fill on bank 1 and read on bank 0, fill_done and comp_done same cycle -> next cycle bank_full=2'b10, both busy low, wr_ptr=0, rd_ptr=1.
- Flush mid-fill then fill_done 3 cycles later -> banks EMPTY, fill_sel=0, err=1; comp_tag unchanged.
- Saturation/error: CNT_WIDTH=4, stall 20 cycles -> stall_cnt=15; spurious comp_done -> err=1 held until rst.
